// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the lock sequencer: state encodings, register map,
// CTRL/STATUS bit positions and neopixel colours.
package lock_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_LOCKED    = 3'd0,
      ST_UNLOCKING = 3'd1,
      ST_OPEN      = 3'd2,
      ST_LOCKING   = 3'd3,
      ST_DENIED    = 3'd4
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_HOLD   = 2'd2;
   localparam logic [1:0] REG_MOVE   = 2'd3;

   localparam int CTRL_GRANT = 0;
   localparam int CTRL_DENY  = 1;
   localparam int CTRL_FORCE = 2;
   localparam int STATUS_EVT = 8;

   localparam logic [23:0] COL_LOCKED = 24'h001000;
   localparam logic [23:0] COL_MOVING = 24'h101000;
   localparam logic [23:0] COL_OPEN   = 24'h100000;
   localparam logic [23:0] COL_OFF    = 24'h000000;

   localparam logic [15:0] BLINK_MS = 16'd250;

   // A programmed duration of zero is treated as one millisecond.
   function automatic logic [15:0] ms_at_least_one(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

endpackage

// File: rtl/lock_sequencer_ms_timer.sv
// Millisecond timer: MS_DIV-cycle prescaler feeding a 16-bit down-counter.
// start restarts both stages; done pulses in the last cycle of the interval.
module lock_sequencer_ms_timer
   import lock_sequencer_pkg::*;
#(
   parameter int MS_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] load_ms,
   output logic        tick,
   output logic        done
);

   localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_DIV - 1);

   logic             active;
   logic [PRE_W-1:0] pre;
   logic [15:0]      ms_left;

   assign tick = active && (pre == {PRE_W{1'b0}});
   assign done = tick && (ms_left == 16'd1);

   // Prescaler and millisecond counter
   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= 1'b0;
         pre     <= {PRE_W{1'b0}};
         ms_left <= 16'd0;
      end else if (start) begin
         active  <= 1'b1;
         pre     <= PRE_MAX;
         ms_left <= ms_at_least_one(load_ms);
      end else if (tick) begin
         pre <= PRE_MAX;
         if (ms_left == 16'd1) begin
            active <= 1'b0;
         end else begin
            ms_left <= ms_left - 16'd1;
         end
      end else if (active) begin
         pre <= pre - {{(PRE_W-1){1'b0}}, 1'b1};
      end else begin
         pre <= pre;
      end
   end

endmodule

// File: rtl/lock_sequencer.sv
// APB-mapped lock sequencer: drives servo and neopixel status colour through
// unlock/hold/lock cycles. Optional event interrupt enabled by LOCK_SEQ_EVT_IRQ_EN.
module lock_sequencer
   import lock_sequencer_pkg::*;
#(
   parameter int               MS_DIV      = 100000,
   parameter int               POS_W       = 16,
   parameter logic [POS_W-1:0] POS_LOCKED  = POS_W'(1000),
   parameter logic [POS_W-1:0] POS_OPEN    = POS_W'(2000),
   parameter int               HOLD_MS_RST = 5000,
   parameter int               MOVE_MS_RST = 500,
   parameter int               DENY_MS     = 1000
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic             bus_write_en,
   input  logic             bus_read_en,
   input  logic [7:0]       bus_addr,
   input  logic [31:0]      bus_write_data,
   output logic [31:0]      bus_read_data,
   input  logic             seq_en,
   output logic [POS_W-1:0] servo_pos,
   output logic             servo_load,
   output logic [23:0]      np_color,
   output logic             np_req,
   input  logic             np_ack,
   output logic             evt_irq
);

   state_t      state, next_state;
   logic [1:0]  reg_sel;
   logic        cmd_wr, grant, deny, force_lock;
   logic        enter, reload;
   logic [15:0] hold_ms, move_ms, timer_load;
   logic        tmr_tick, tmr_done;
   logic        blink;
   logic [15:0] blink_cnt;
   logic [23:0] target_color;
   logic        evt;
   logic        unused_bits;

   assign reg_sel     = bus_addr[3:2];
   assign cmd_wr      = seq_en && bus_write_en && (reg_sel == REG_CTRL);
   assign grant       = cmd_wr && bus_write_data[CTRL_GRANT];
   assign deny        = cmd_wr && bus_write_data[CTRL_DENY];
   assign force_lock  = cmd_wr && bus_write_data[CTRL_FORCE];
   assign unused_bits = ^{bus_addr[7:4], bus_addr[1:0], bus_write_data[31:16]};

   lock_sequencer_ms_timer #(.MS_DIV(MS_DIV)) u_timer (
      .clk     (pclk),
      .reset   (reset),
      .start   (enter || reload),
      .load_ms (timer_load),
      .tick    (tmr_tick),
      .done    (tmr_done)
   );

   // Next state; force_lock outranks deny, which outranks grant
   always_comb begin
      next_state = state;
      reload     = 1'b0;
      case (state)
         ST_LOCKED: begin
            if (deny)            next_state = ST_DENIED;
            else if (grant)      next_state = ST_UNLOCKING;
            else                 next_state = state;
         end
         ST_UNLOCKING: begin
            if (force_lock)      next_state = ST_LOCKING;
            else if (tmr_done)   next_state = ST_OPEN;
            else                 next_state = state;
         end
         ST_OPEN: begin
            if (force_lock)      next_state = ST_LOCKING;
            else if (grant)      reload     = 1'b1;
            else if (tmr_done)   next_state = ST_LOCKING;
            else                 next_state = state;
         end
         ST_LOCKING: begin
            if (force_lock)      next_state = state;
            else if (grant)      next_state = ST_UNLOCKING;
            else if (tmr_done)   next_state = ST_LOCKED;
            else                 next_state = state;
         end
         ST_DENIED: begin
            if (force_lock)      next_state = ST_LOCKING;
            else if (tmr_done)   next_state = ST_LOCKED;
            else                 next_state = state;
         end
         default:                next_state = ST_LOCKED;
      endcase
      enter = (next_state != state);
      case (next_state)
         ST_OPEN:                   timer_load = hold_ms;
         ST_UNLOCKING, ST_LOCKING:  timer_load = move_ms;
         default:                   timer_load = 16'(DENY_MS);
      endcase
   end

   // Colour implied by the current state
   always_comb begin
      case (state)
         ST_LOCKED:                 target_color = COL_LOCKED;
         ST_UNLOCKING, ST_LOCKING:  target_color = COL_MOVING;
         ST_OPEN:                   target_color = COL_OPEN;
         ST_DENIED:                 target_color = blink ? COL_OFF : COL_LOCKED;
         default:                   target_color = COL_LOCKED;
      endcase
   end

   // State, servo command, timing registers, blink phase and colour handshake
   always_ff @(posedge pclk) begin
      if (reset) begin
         state      <= ST_LOCKED;
         servo_pos  <= POS_LOCKED;
         servo_load <= 1'b0;
         hold_ms    <= 16'(HOLD_MS_RST);
         move_ms    <= 16'(MOVE_MS_RST);
         blink      <= 1'b0;
         blink_cnt  <= 16'd0;
         np_color   <= COL_LOCKED;
         np_req     <= 1'b1;
      end else begin
         state      <= next_state;
         servo_load <= 1'b0;
         if (enter && (next_state == ST_UNLOCKING)) begin
            servo_pos  <= POS_OPEN;
            servo_load <= 1'b1;
         end else if (enter && (next_state == ST_LOCKING)) begin
            servo_pos  <= POS_LOCKED;
            servo_load <= 1'b1;
         end
         if (seq_en && bus_write_en && (reg_sel == REG_HOLD)) hold_ms <= bus_write_data[15:0];
         if (seq_en && bus_write_en && (reg_sel == REG_MOVE)) move_ms <= bus_write_data[15:0];
         if (enter) begin
            blink     <= 1'b0;
            blink_cnt <= 16'd0;
         end else if ((state == ST_DENIED) && tmr_tick) begin
            if (blink_cnt == BLINK_MS - 16'd1) begin
               blink     <= ~blink;
               blink_cnt <= 16'd0;
            end else begin
               blink_cnt <= blink_cnt + 16'd1;
            end
         end
         // A new colour always re-arms the request, even when ack arrives together
         if (target_color != np_color) begin
            np_color <= target_color;
            np_req   <= 1'b1;
         end else if (np_ack) begin
            np_req <= 1'b0;
         end
      end
   end

`ifdef LOCK_SEQ_EVT_IRQ_EN
   // Sticky event on OPEN/LOCKED entry; a set beats a same-cycle clear
   always_ff @(posedge pclk) begin
      if (reset) begin
         evt <= 1'b0;
      end else if (enter && ((next_state == ST_OPEN) || (next_state == ST_LOCKED))) begin
         evt <= 1'b1;
      end else if (seq_en && bus_write_en && (reg_sel == REG_STATUS) && bus_write_data[STATUS_EVT]) begin
         evt <= 1'b0;
      end else begin
         evt <= evt;
      end
   end
`else
   assign evt = 1'b0;
`endif

   assign evt_irq = evt;

   // Register read mux
   always_comb begin
      bus_read_data = 32'd0;
      if (seq_en && bus_read_en) begin
         case (reg_sel)
            REG_STATUS: bus_read_data = {23'd0, evt, 4'd0, np_req, state};
            REG_HOLD:   bus_read_data = {16'd0, hold_ms};
            REG_MOVE:   bus_read_data = {16'd0, move_ms};
            default:    bus_read_data = 32'd0;
         endcase
      end else begin
         bus_read_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer with MS_DIV=10: register vectors,
// servo-load scoreboard and hand-written timing sequences.
module tb_lock_sequencer;

   logic        pclk = 1'b0;
   logic        reset, bus_write_en, bus_read_en, seq_en, np_ack;
   logic [7:0]  bus_addr;
   logic [31:0] bus_write_data, bus_read_data;
   logic [15:0] servo_pos;
   logic        servo_load;
   logic [23:0] np_color;
   logic        np_req, evt_irq;

   int          n_chk = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_pos;
   logic [31:0] rdat;

   typedef struct {
      logic        do_wr;
      logic        wsel;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        rsel;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[7];

   lock_sequencer #(.MS_DIV(10)) dut (
      .pclk           (pclk),
      .reset          (reset),
      .bus_write_en   (bus_write_en),
      .bus_read_en    (bus_read_en),
      .bus_addr       (bus_addr),
      .bus_write_data (bus_write_data),
      .bus_read_data  (bus_read_data),
      .seq_en         (seq_en),
      .servo_pos      (servo_pos),
      .servo_load     (servo_load),
      .np_color       (np_color),
      .np_req         (np_req),
      .np_ack         (np_ack),
      .evt_irq        (evt_irq)
   );

   always #5 pclk = ~pclk;

   // Scoreboard: every servo_load pulse must match the next queued position
   always @(negedge pclk) begin
      if (servo_load === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL servo_load: unexpected pulse, pos=%0d, required no pulse", servo_pos);
         end else begin
            exp_pos = exp_q.pop_front();
            if (servo_pos !== exp_pos) begin
               n_fail++;
               $display("FAIL servo_pos: got %0d, required %0d", servo_pos, exp_pos);
            end
         end
      end
   end

   always @(posedge pclk) begin
      if ((np_req === 1'b1) && (np_ack === 1'b1)) acc_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic wr(input logic sel, input logic [7:0] a, input logic [31:0] d);
      seq_en = sel; bus_addr = a; bus_write_data = d; bus_write_en = 1'b1;
      step(1);
      bus_write_en = 1'b0; seq_en = 1'b0;
   endtask

   task automatic rd(input logic sel, input logic [7:0] a, output logic [31:0] d);
      seq_en = sel; bus_addr = a; bus_read_en = 1'b1;
      #1;
      d = bus_read_data;
      bus_read_en = 1'b0; seq_en = 1'b0;
   endtask

   task automatic check_state(input string name, input logic [2:0] exp);
      logic [31:0] d;
      rd(1'b1, 8'h04, d);
      check(name, {29'd0, d[2:0]}, {29'd0, exp});
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 8'h08, 32'hFFFF_0007, 1'b1, 32'h0000_0007, "hold_upper_ignored"};
      vecs[1] = '{1'b1, 1'b1, 8'h08, 32'h0000_0003, 1'b1, 32'h0000_0003, "hold_rw"};
      vecs[2] = '{1'b1, 1'b1, 8'h0C, 32'h0000_0002, 1'b1, 32'h0000_0002, "move_rw"};
      vecs[3] = '{1'b0, 1'b1, 8'h00, 32'h0000_0000, 1'b1, 32'h0000_0000, "ctrl_reads_0"};
      vecs[4] = '{1'b0, 1'b1, 8'h04, 32'h0000_0000, 1'b1, 32'h0000_0000, "status_idle"};
      vecs[5] = '{1'b0, 1'b1, 8'h08, 32'h0000_0000, 1'b0, 32'h0000_0000, "read_unselected"};
      vecs[6] = '{1'b1, 1'b0, 8'h08, 32'h0000_0055, 1'b1, 32'h0000_0003, "write_unselected"};

      reset = 1'b1; bus_write_en = 1'b0; bus_read_en = 1'b0; seq_en = 1'b0;
      np_ack = 1'b0; bus_addr = 8'h00; bus_write_data = 32'd0;
      step(3);
      reset = 1'b0;

      // Reset state
      check_state("reset_state", 3'd0);
      check("reset_servo_pos", servo_pos, 32'd1000);
      check("reset_servo_load", servo_load, 32'd0);
      check("reset_np_color", np_color, 32'h001000);
      check("reset_np_req", np_req, 32'd1);
      check("reset_evt_irq", evt_irq, 32'd0);
      step(2);
      check("np_req_held_no_ack", np_req, 32'd1);
      np_ack = 1'b1;
      step(1);
      check("np_req_cleared_by_ack", np_req, 32'd0);

      // Register vectors
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_wr) wr(vecs[i].wsel, vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].rsel, vecs[i].addr, rdat);
         check(vecs[i].name, rdat, vecs[i].exp);
         step(1);
      end

      // Full unlock / hold / lock cycle
      exp_q.push_back(16'd2000);
      wr(1'b1, 8'h00, 32'd1);
      check_state("grant_unlocking", 3'd1);
      step(19);
      check_state("unlocking_at_19", 3'd1);
      step(1);
      check_state("open_at_20", 3'd2);
      step(1);
      check("open_color", np_color, 32'h100000);
      step(28);
      check_state("open_at_29", 3'd2);
      exp_q.push_back(16'd1000);
      step(1);
      check_state("locking_at_30", 3'd3);
      step(19);
      check_state("locking_at_19", 3'd3);
      step(1);
      check_state("locked_at_20", 3'd0);

      // Deny wins over grant; grant ignored while denied; blink
      wr(1'b1, 8'h00, 32'd3);
      check_state("deny_wins", 3'd4);
      step(5);
      wr(1'b1, 8'h00, 32'd1);
      check_state("grant_ignored_denied", 3'd4);
      step(994);
      check("denied_color_on", np_color, 32'h001000);
      step(1600);
      check("denied_color_off", np_color, 32'h000000);
      step(7399);
      check_state("denied_at_9999", 3'd4);
      step(1);
      check_state("locked_after_deny", 3'd0);
      step(2);
      check("locked_color_restored", np_color, 32'h001000);

      // Grant in OPEN reloads hold
      exp_q.push_back(16'd2000);
      wr(1'b1, 8'h00, 32'd1);
      step(20);
      check_state("open_before_reload", 3'd2);
      step(24);
      wr(1'b1, 8'h00, 32'd1);
      step(29);
      check_state("open_extended", 3'd2);
      exp_q.push_back(16'd1000);
      step(1);
      check_state("locking_after_extend", 3'd3);
      step(20);
      check_state("locked_after_extend", 3'd0);

      // Force lock from OPEN and UNLOCKING; grant in LOCKING
      exp_q.push_back(16'd2000);
      wr(1'b1, 8'h00, 32'd1);
      step(20);
      exp_q.push_back(16'd1000);
      wr(1'b1, 8'h00, 32'd4);
      check_state("force_from_open", 3'd3);
      step(5);
      exp_q.push_back(16'd2000);
      wr(1'b1, 8'h00, 32'd1);
      check_state("grant_in_locking", 3'd1);
      step(3);
      exp_q.push_back(16'd1000);
      wr(1'b1, 8'h00, 32'd4);
      check_state("force_from_unlocking", 3'd3);
      step(20);
      check_state("locked_after_force", 3'd0);

      // Colour requests coalesce while ack is held off
      np_ack = 1'b0;
      exp_q.push_back(16'd2000);
      wr(1'b1, 8'h00, 32'd1);
      step(22);
      check("coalesced_color", np_color, 32'h100000);
      check("coalesced_req", np_req, 32'd1);
      acc_cnt = 0;
      np_ack = 1'b1;
      step(3);
      check("single_acceptance", acc_cnt, 32'd1);
      check("req_clear_after_ack", np_req, 32'd0);
      exp_q.push_back(16'd1000);
      wr(1'b1, 8'h00, 32'd4);
      step(20);
      check_state("locked_before_evt", 3'd0);

`ifdef LOCK_SEQ_EVT_IRQ_EN
      wr(1'b1, 8'h04, 32'h100);
      check("evt_cleared", evt_irq, 32'd0);
      exp_q.push_back(16'd2000);
      wr(1'b1, 8'h00, 32'd1);
      step(19);
      check("evt_before_open", evt_irq, 32'd0);
      step(1);
      check("evt_on_open", evt_irq, 32'd1);
      wr(1'b1, 8'h04, 32'h100);
      check("evt_w1c", evt_irq, 32'd0);
      exp_q.push_back(16'd1000);
      wr(1'b1, 8'h00, 32'd4);
      step(19);
      wr(1'b1, 8'h04, 32'h100);
      check_state("locked_with_w1c", 3'd0);
      check("evt_set_wins", evt_irq, 32'd1);
      rd(1'b1, 8'h04, rdat);
      check("status_evt_bit", {31'd0, rdat[8]}, 32'd1);
`else
      wr(1'b1, 8'h04, 32'h100);
      check("evt_irq_tied_low", evt_irq, 32'd0);
      rd(1'b1, 8'h04, rdat);
      check("status_evt_reads_0", {31'd0, rdat[8]}, 32'd0);
`endif

      step(2);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
